// File: rtl/loopers_pkg.sv
// rtl/loopers_pkg.sv - shared constants and FSM encodings for the address scheduler
package loopers_pkg;

    localparam int ADDR_W        = 16;
    localparam int TAG_W_DEFAULT = 6;

    // Result-slot occupancy, derived from res_vld / res_rdy history.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/adr_sched_if.sv
// rtl/adr_sched_if.sv - request/adder/result bundle between issue slots, adder and LSQ
// Signals:
//   req_vld/req_op1/req_op2/req_tag/req_ld  requester side (flattened per slot)
//   req_gnt                                 one-hot grant back to requesters
//   addr_op1/addr_op2/addr_en/addr_out      external shared adder
//   res_vld/res_addr/res_tag/res_ld/res_rdy result handshake toward the LSQ
// Modports: master = scheduler, slave = surrounding environment.
interface adr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 16
) ();
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_ld;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [DATA_W-1:0]         addr_op1;
    logic [DATA_W-1:0]         addr_op2;
    logic                      addr_en;
    logic [DATA_W-1:0]         addr_out;
    logic                      res_vld;
    logic [DATA_W-1:0]         res_addr;
    logic [TAG_W-1:0]          res_tag;
    logic                      res_ld;
    logic                      res_rdy;

    modport master (
        input  req_vld, req_op1, req_op2, req_tag, req_ld, addr_out, res_rdy,
        output req_gnt, addr_op1, addr_op2, addr_en, res_vld, res_addr, res_tag, res_ld
    );

    modport slave (
        output req_vld, req_op1, req_op2, req_tag, req_ld, addr_out, res_rdy,
        input  req_gnt, addr_op1, addr_op2, addr_en, res_vld, res_addr, res_tag, res_ld
    );
endinterface

// File: rtl/adr_sched_rr_arb.sv
// rtl/adr_sched_rr_arb.sv - N-wide round-robin picker starting at a given pointer
// Ports:
//   i_req  request vector
//   i_ptr  slot with highest priority this cycle
//   i_en   when low no grant is produced
//   o_gnt  one-hot grant (all zero when nothing granted)
//   o_idx  encoded winner index (0 when nothing granted)
module rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx
);
    always_comb begin
        int               w_k;
        logic [PTR_W-1:0] w_kidx;
        logic             w_found;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        w_kidx  = '0;
        // Scan from the pointer upward, wrapping at N.
        for (int i = 0; i < N; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            w_kidx = w_k[PTR_W-1:0];
            if (i_en && !w_found && i_req[w_kidx]) begin
                w_found       = 1'b1;
                o_gnt[w_kidx] = 1'b1;
                o_idx         = w_kidx;
            end
        end
    end
endmodule

// File: rtl/adr_sched.sv
// rtl/adr_sched.sv - round-robin sharing of one address adder among load/store issue slots
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   flush      synchronous mispredict flush; drops the held result, no grant that cycle
//   bus        adr_sched_if.master: requests, grant, adder operands/sum, result handshake
//   stall_cnt  saturating count of cycles spent in STALL (only with ADR_SCHED_STALL_CNT_EN)
// Optional feature macro: ADR_SCHED_STALL_CNT_EN
module adr_sched
    import loopers_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = TAG_W_DEFAULT,
    parameter int DATA_W  = ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    adr_sched_if.master  bus
`ifdef ADR_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0]  r_res_addr;
    logic [TAG_W-1:0]   r_res_tag;
    logic               r_res_ld;

    logic               w_res_vld;
    logic               w_slot_free;
    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_idx;
    logic               w_grant;
    logic [DATA_W-1:0]  w_op1;
    logic [DATA_W-1:0]  w_op2;
    logic [TAG_W-1:0]   w_tag;
    logic               w_ld;

    assign w_res_vld   = (r_state != ST_EMPTY);
    assign w_slot_free = !w_res_vld || bus.res_rdy;
    // rst gating keeps the combinational grant path quiet while reset is held.
    assign w_arb_en    = w_slot_free && !flush && !rst;

    rr_arb #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .i_req (bus.req_vld),
        .i_ptr (r_rr_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_grant = |w_gnt;

    // One-hot AND-OR mux; all zero when nothing is granted.
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        w_tag = '0;
        w_ld  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op1 = w_op1 | bus.req_op1[i*DATA_W +: DATA_W];
                w_op2 = w_op2 | bus.req_op2[i*DATA_W +: DATA_W];
                w_tag = w_tag | bus.req_tag[i*TAG_W +: TAG_W];
                w_ld  = w_ld  | bus.req_ld[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_grant) begin
            w_state_nxt = ST_VALID;
        end else if (w_res_vld && !bus.res_rdy) begin
            w_state_nxt = ST_STALL;
        end else begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_rr_ptr   <= '0;
            r_res_addr <= '0;
            r_res_tag  <= '0;
            r_res_ld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_res_addr <= bus.addr_out;
                r_res_tag  <= w_tag;
                r_res_ld   <= w_ld;
                r_rr_ptr   <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

`ifdef ADR_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == ST_STALL && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.req_gnt  = w_gnt;
    assign bus.addr_en  = w_grant;
    assign bus.addr_op1 = w_op1;
    assign bus.addr_op2 = w_op2;
    assign bus.res_vld  = w_res_vld;
    assign bus.res_addr = r_res_addr;
    assign bus.res_tag  = r_res_tag;
    assign bus.res_ld   = r_res_ld;
endmodule

// File: tb/tb_adr_sched.sv
// tb/tb_adr_sched.sv - directed self-checking bench for adr_sched
module tb_adr_sched;
    logic clk;
    logic rst;
    logic flush;
`ifdef ADR_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    adr_sched_if #(.NUM_REQ(4), .TAG_W(6), .DATA_W(16)) bus ();

    // External adder, as the block expects.
    assign bus.addr_out = bus.addr_op1 + bus.addr_op2;

    adr_sched #(.NUM_REQ(4), .TAG_W(6), .DATA_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef ADR_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Slot i: op1 = 0x0100*(i+1), op2 = 0x0010*(i+1) -> sum 0x0110*(i+1); tag = 10+i; ld = i odd.
    task automatic set_operands;
        for (int i = 0; i < 4; i++) begin
            bus.req_op1[i*16 +: 16] = 16'(16'h0100 * (i + 1));
            bus.req_op2[i*16 +: 16] = 16'(16'h0010 * (i + 1));
            bus.req_tag[i*6 +: 6]   = 6'(10 + i);
            bus.req_ld[i]           = (i % 2) == 1;
        end
    endtask

    task automatic do_reset;
        bus.req_vld = 4'b0000;
        bus.res_rdy = 1'b1;
        flush       = 1'b0;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        set_operands();
    endtask

    task automatic test_reset;
        bus.req_vld = 4'b1111;
        bus.res_rdy = 1'b1;
        #2;
        checks++;
        if (bus.req_gnt !== 4'b0000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.req_gnt);
        end
        checks++;
        if (bus.addr_en !== 1'b0 || bus.addr_op1 !== 16'h0 || bus.addr_op2 !== 16'h0) begin
            failures++; $display("FAIL reset_addr got en=%b op1=%h op2=%h exp 0", bus.addr_en, bus.addr_op1, bus.addr_op2);
        end
        checks++;
        if (bus.res_vld !== 1'b0 || bus.res_addr !== 16'h0 || bus.res_tag !== 6'h0 || bus.res_ld !== 1'b0) begin
            failures++; $display("FAIL reset_res got vld=%b addr=%h tag=%h ld=%b exp 0", bus.res_vld, bus.res_addr, bus.res_tag, bus.res_ld);
        end
`ifdef ADR_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'h0) begin
            failures++; $display("FAIL reset_stall_cnt got=%h exp=0000", stall_cnt);
        end
`endif
        bus.req_vld = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        bus.req_op1[15:0] = 16'h1000;
        bus.req_op2[15:0] = 16'h0024;
        bus.req_tag[5:0]  = 6'd5;
        bus.req_ld[0]     = 1'b1;
        bus.req_vld       = 4'b0001;
        bus.res_rdy       = 1'b1;
        #1;
        checks++;
        if (bus.req_gnt !== 4'b0001 || bus.addr_en !== 1'b1) begin
            failures++; $display("FAIL single_gnt got gnt=%b en=%b exp gnt=0001 en=1", bus.req_gnt, bus.addr_en);
        end
        checks++;
        if (bus.addr_op1 !== 16'h1000 || bus.addr_op2 !== 16'h0024) begin
            failures++; $display("FAIL single_ops got %h %h exp 1000 0024", bus.addr_op1, bus.addr_op2);
        end
        step();
        bus.req_vld = 4'b0000;
        checks++;
        if (bus.res_vld !== 1'b1 || bus.res_addr !== 16'h1024 || bus.res_tag !== 6'd5 || bus.res_ld !== 1'b1) begin
            failures++; $display("FAIL single_res got vld=%b addr=%h tag=%0d ld=%b exp 1 1024 5 1", bus.res_vld, bus.res_addr, bus.res_tag, bus.res_ld);
        end
        step();
        checks++;
        if (bus.res_vld !== 1'b0) begin
            failures++; $display("FAIL single_drain got vld=%b exp=0", bus.res_vld);
        end
    endtask

    task automatic test_fairness;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_addr;
        do_reset();
        bus.req_vld = 4'b1111;
        bus.res_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_gnt  = 4'b0001 << (c % 4);
            exp_addr = 16'(16'h0110 * ((c % 4) + 1));
            #1;
            checks++;
            if (bus.req_gnt !== exp_gnt) begin
                failures++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", c, bus.req_gnt, exp_gnt);
            end
            step();
            checks++;
            if (bus.res_vld !== 1'b1 || bus.res_addr !== exp_addr || bus.res_tag !== 6'(10 + (c % 4))) begin
                failures++; $display("FAIL fair_res[%0d] got vld=%b addr=%h tag=%0d exp 1 %h %0d", c, bus.res_vld, bus.res_addr, bus.res_tag, exp_addr, 10 + (c % 4));
            end
        end
        bus.req_vld = 4'b0000;
        step();
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.req_vld = 4'b0011;
        bus.res_rdy = 1'b1;
        step();
        bus.res_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.req_gnt !== 4'b0000 || bus.addr_en !== 1'b0) begin
                failures++; $display("FAIL bp_gnt[%0d] got gnt=%b en=%b exp 0000 0", c, bus.req_gnt, bus.addr_en);
            end
            step();
            checks++;
            if (bus.res_vld !== 1'b1 || bus.res_addr !== 16'h0110 || bus.res_tag !== 6'd10) begin
                failures++; $display("FAIL bp_hold[%0d] got vld=%b addr=%h tag=%0d exp 1 0110 10", c, bus.res_vld, bus.res_addr, bus.res_tag);
            end
        end
        bus.res_rdy = 1'b1;
        #1;
        checks++;
        if (bus.req_gnt !== 4'b0010) begin
            failures++; $display("FAIL bp_release_gnt got=%b exp=0010", bus.req_gnt);
        end
        step();
        bus.req_vld = 4'b0000;
        checks++;
        if (bus.res_vld !== 1'b1 || bus.res_addr !== 16'h0220 || bus.res_tag !== 6'd11 || bus.res_ld !== 1'b1) begin
            failures++; $display("FAIL bp_release_res got vld=%b addr=%h tag=%0d ld=%b exp 1 0220 11 1", bus.res_vld, bus.res_addr, bus.res_tag, bus.res_ld);
        end
`ifdef ADR_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            failures++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt);
        end
`endif
        step();
    endtask

    task automatic test_wrap;
        do_reset();
        bus.req_op1[32 +: 16] = 16'hFFFF;
        bus.req_op2[32 +: 16] = 16'h0002;
        bus.req_vld = 4'b0100;
        bus.res_rdy = 1'b1;
        #1;
        checks++;
        if (bus.req_gnt !== 4'b0100) begin
            failures++; $display("FAIL wrap_gnt2 got=%b exp=0100", bus.req_gnt);
        end
        step();
        checks++;
        if (bus.res_addr !== 16'h0001) begin
            failures++; $display("FAIL wrap_sum got=%h exp=0001", bus.res_addr);
        end
        bus.req_vld = 4'b1001;
        #1;
        checks++;
        if (bus.req_gnt !== 4'b1000) begin
            failures++; $display("FAIL wrap_gnt3 got=%b exp=1000", bus.req_gnt);
        end
        step();
        checks++;
        if (bus.res_addr !== 16'h0440 || bus.res_tag !== 6'd13) begin
            failures++; $display("FAIL wrap_res3 got addr=%h tag=%0d exp 0440 13", bus.res_addr, bus.res_tag);
        end
        #1;
        checks++;
        if (bus.req_gnt !== 4'b0001) begin
            failures++; $display("FAIL wrap_gnt0 got=%b exp=0001", bus.req_gnt);
        end
        step();
        bus.req_vld = 4'b0000;
        step();
    endtask

    task automatic test_flush;
        do_reset();
        bus.req_vld = 4'b0001;
        bus.res_rdy = 1'b1;
        step();
        flush       = 1'b1;
        bus.req_vld = 4'b0010;
        #1;
        checks++;
        if (bus.req_gnt !== 4'b0000 || bus.addr_en !== 1'b0) begin
            failures++; $display("FAIL flush_nogrant got gnt=%b en=%b exp 0000 0", bus.req_gnt, bus.addr_en);
        end
        step();
        flush = 1'b0;
        checks++;
        if (bus.res_vld !== 1'b0) begin
            failures++; $display("FAIL flush_drop got vld=%b exp=0", bus.res_vld);
        end
        #1;
        checks++;
        if (bus.req_gnt !== 4'b0010) begin
            failures++; $display("FAIL flush_after_gnt got=%b exp=0010", bus.req_gnt);
        end
        step();
        bus.req_vld = 4'b0000;
        checks++;
        if (bus.res_vld !== 1'b1 || bus.res_addr !== 16'h0220) begin
            failures++; $display("FAIL flush_after_res got vld=%b addr=%h exp 1 0220", bus.res_vld, bus.res_addr);
        end
        step();
    endtask

    task automatic test_async_rst;
        do_reset();
        bus.req_vld = 4'b0001;
        bus.res_rdy = 1'b1;
        step();
        bus.req_vld = 4'b0000;
        bus.res_rdy = 1'b0;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.res_vld !== 1'b0 || bus.res_addr !== 16'h0) begin
            failures++; $display("FAIL async_rst got vld=%b addr=%h exp 0 0000", bus.res_vld, bus.res_addr);
        end
`ifdef ADR_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'h0) begin
            failures++; $display("FAIL async_rst_stall_cnt got=%0d exp=0", stall_cnt);
        end
`endif
        step();
        rst         = 1'b0;
        bus.res_rdy = 1'b1;
        step();
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        bus.req_vld = '0;
        bus.req_op1 = '0;
        bus.req_op2 = '0;
        bus.req_tag = '0;
        bus.req_ld  = '0;
        bus.res_rdy = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_flush();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
